datamem_sized: RTL and testbench
================================

Name: datamem_sized

Overview:
- Parametrised data memory for the MEM stage of the pipelined MIPS core.
- Supports byte-addressed byte, halfword and word loads and stores (lb/lbu/lh/lhu/lw/sb/sh/sw).
- Loads are registered and sign- or zero-extended; misaligned accesses are detected and flagged.
- An optional power-on clear sequencer zeroes the array after reset.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, minimum 4.
- ADDR_W, $clog2(DEPTH)+2, number of byte-address bits decoded. Higher bits of A are ignored, so addresses wrap.
- INIT_CLEAR, 1, 1 = run the zeroing sequencer after reset; 0 = array contents undefined after reset and busy never asserts.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- WE  in  1  store request.
- memread  in  1  load request.
- A  in  32  byte address; word index = A[ADDR_W-1:2], byte lane = A[1:0].
- WD  in  32  store data, right-justified (sb uses WD[7:0], sh uses WD[15:0]).
- size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- sign_ext  in  1  1 = sign-extend sub-word loads; 0 = zero-extend.
- RD  out  32  registered load data.
- rd_valid  out  1  one-cycle pulse, RD updated this cycle.
- misalign  out  1  one-cycle pulse, previous request rejected.
- busy  out  1  clear sequencer active; all requests ignored.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - RD=0, rd_valid=0, misalign=0, clear pointer=0.
  - FSM enters CLEAR if INIT_CLEAR=1, otherwise IDLE.
  - busy=INIT_CLEAR.
- FSM states:
  - CLEAR: write 0 to word[ptr] each cycle and increment ptr. After writing DEPTH-1, go to IDLE on the next edge. busy is high for exactly DEPTH cycles after rst_n rises.
  - IDLE: serve requests.
  - Reset asserted mid-CLEAR restarts the sequence at ptr=0.
- Requests in CLEAR: WE and memread are ignored; no write, rd_valid=0, misalign=0.
- Alignment rules:
  - half requires A[0]=0; word requires A[1:0]=00.
  - size=11 is always an error.
  - Error case: no array write, RD holds, rd_valid=0, misalign=1 for one cycle following the request edge.
  - misalign asserts only if WE or memread is high.
- Store (WE=1, aligned, IDLE): at the clock edge, write only the addressed lanes.
  - sb: lane A[1:0] = WD[7:0].
  - sh: lanes {A[1],1}:{A[1],0} = WD[15:0], little-endian (A[1]=0 writes bits 15:0).
  - sw: all four lanes.
  - Untouched lanes keep their value.
- Load (memread=1, aligned, IDLE):
  - RD and rd_valid=1 update at the request edge, so data is visible one cycle after the request is presented.
  - Extract the lane(s) selected by A and size, then extend to 32 bits per sign_ext. The word case ignores sign_ext.
- No valid load: rd_valid=0 and RD holds its last value.
- Simultaneous WE and memread on the same address: read-first. RD returns pre-store contents and the store still commits. Both use the same A and size; a misalignment rejects both.
- Back-to-back loads: one per cycle, full throughput, no bubbles.
- Back-to-back store then load to the same word: the load on the next cycle sees the stored data.
- Address wrap: A=DEPTH*4+k aliases byte k.
- The array is an inferred synchronous-write register/RAM with no combinational read path to RD.

Test Plan (DEPTH=64, INIT_CLEAR=1):
- Release rst_n → busy high for exactly 64 cycles. Then lw at 0x00, 0x7C and 0xFC each return 0 with rd_valid pulses. WE=1 during busy with WD=0xFFFFFFFF at 0x10 → later lw 0x10 returns 0.
- sw 0x12345678 @0x20, then lb @0x20/0x21/0x22/0x23 → 0x78, 0x56, 0x34, 0x12. lh @0x22 → 0x1234.
- sw 0x80FF7F80 @0x40 →
  - lb @0x40, sign_ext=1 → 0xFFFFFF80; sign_ext=0 → 0x00000080.
  - lh @0x42, sign_ext=1 → 0xFFFF80FF; sign_ext=0 → 0x000080FF.
- sw 0xAAAAAAAA @0x30, then sb 0x11 @0x31 and sh 0x2233 @0x32 → lw @0x30 = 0x223311AA.
- Misalignment checks, each producing a 1-cycle misalign pulse with rd_valid=0 and no array write:
  - lw @0x05; sh @0x33; size=11 @0x00.
  - Confirm lw @0x04 and @0x30 afterwards are unchanged.
- Interaction checks:
  - WE+memread both high, sw 0x5555 @0x50 over prior 0x1111 → RD=0x1111 that cycle; next-cycle lw @0x50 → 0x5555.
  - sw 0xCAFE @0x104 aliases 0x04 → lw @0x04 → 0xCAFE.
  - Assert rst_n=0 at cycle 20 of CLEAR → all outputs reset immediately and busy spans 64 cycles from the new release.

Source files
------------

// File: rtl/datamem_sized.sv
// datamem_sized: byte-addressed data memory for the MEM stage of the pipelined
// MIPS core. Supports byte, halfword and word loads and stores. Loads are
// registered and sign- or zero-extended. Misaligned requests are rejected and
// flagged. An optional power-on clear sequencer zeroes the array after reset.
//
// Ports:
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   WE        store request
//   memread   load request
//   A         byte address (word = A[ADDR_W-1:2], lane = A[1:0])
//   WD        store data, right-justified
//   size      00 byte, 01 half, 10 word, 11 reserved (always rejected)
//   sign_ext  1 = sign-extend sub-word loads, 0 = zero-extend
//   RD        registered load data
//   rd_valid  one-cycle pulse, RD updated
//   misalign  one-cycle pulse, previous request rejected
//   busy      clear sequencer active, requests ignored
//
// state   | meaning
// --------+-------------------------------------------------
// S_CLEAR | writing zero to word[ptr], one word per cycle
// S_IDLE  | serving load/store requests
module datamem_sized #(
    parameter int DEPTH      = 256,
    parameter int ADDR_W     = $clog2(DEPTH) + 2,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        WE,
    input  logic        memread,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] RD,
    output logic        rd_valid,
    output logic        misalign,
    output logic        busy
);

    localparam int IDX_W = ADDR_W - 2;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;

    logic [31:0] mem [DEPTH];

    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             bad_align;

    logic             mem_we;
    logic [IDX_W-1:0] wr_idx;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;
    logic             load_ok;
    logic             err;

    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ld_data;

    // Upper address bits are not decoded, so addresses wrap.
    logic unused_addr;
    assign unused_addr = ^A[31:ADDR_W];

    assign idx  = A[ADDR_W-1:2];
    assign lane = A[1:0];
    assign busy = (state == S_CLEAR);

    always_comb begin
        bad_align = 1'b0;
        case (size)
            2'b00:   bad_align = 1'b0;
            2'b01:   bad_align = A[0];
            2'b10:   bad_align = (A[1:0] != 2'b00);
            default: bad_align = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT_CLEAR ? S_CLEAR : S_IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        mem_we    = 1'b0;
        wr_idx    = idx;
        wr_be     = 4'b0000;
        wr_data   = 32'h0;
        load_ok   = 1'b0;
        err       = 1'b0;
        case (state)
            S_CLEAR: begin
                mem_we  = 1'b1;
                wr_idx  = ptr;
                wr_be   = 4'b1111;
                ptr_nxt = ptr + IDX_W'(1);
                if (ptr == LAST) state_nxt = S_IDLE;
            end
            S_IDLE: begin
                err     = (WE || memread) && bad_align;
                load_ok = memread && !bad_align;
                if (WE && !bad_align) begin
                    mem_we = 1'b1;
                    case (size)
                        2'b00: begin
                            wr_be   = 4'b0001 << lane;
                            wr_data = {4{WD[7:0]}};
                        end
                        2'b01: begin
                            wr_be   = A[1] ? 4'b1100 : 4'b0011;
                            wr_data = {2{WD[15:0]}};
                        end
                        default: begin
                            wr_be   = 4'b1111;
                            wr_data = WD;
                        end
                    endcase
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Lane-masked synchronous write; replicated data lets the byte enables
    // alone select which lanes change.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        rd_word = mem[idx];
        rd_byte = rd_word[{lane, 3'b000} +: 8];
        rd_half = A[1] ? rd_word[31:16] : rd_word[15:0];
        case (size)
            2'b00:   ld_data = sign_ext ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
            2'b01:   ld_data = sign_ext ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
            default: ld_data = rd_word;
        endcase
    end

    // The read samples the array before the same-edge store lands (read-first).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RD       <= 32'h0;
            rd_valid <= 1'b0;
            misalign <= 1'b0;
        end else begin
            rd_valid <= load_ok;
            misalign <= err;
            if (load_ok) RD <= ld_data;
        end
    end

endmodule

// File: tb/tb_datamem_sized.sv
module tb_datamem_sized;

    localparam int DEPTH = 64;
    localparam int NBYTE = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        WE = 1'b0;
    logic        memread = 1'b0;
    logic [31:0] A = 32'h0;
    logic [31:0] WD = 32'h0;
    logic [1:0]  size = 2'b10;
    logic        sign_ext = 1'b0;
    logic [31:0] RD;
    logic        rd_valid;
    logic        misalign;
    logic        busy;

    datamem_sized #(.DEPTH(DEPTH), .INIT_CLEAR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .WE(WE), .memread(memread), .A(A), .WD(WD),
        .size(size), .sign_ext(sign_ext), .RD(RD), .rd_valid(rd_valid),
        .misalign(misalign), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: flat byte array plus the last loaded value.
    logic [7:0]  mdl [NBYTE];
    logic [31:0] exp_rd = 32'h0;
    logic        exp_v = 1'b0;
    logic        exp_m = 1'b0;

    typedef struct {
        logic        we;
        logic        rd;
        logic [31:0] a;
        logic [31:0] wd;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] erd;
        logic        ev;
        logic        em;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic we, rd, input logic [31:0] a, wd,
                                input logic [1:0] sz, input logic sx,
                                input logic [31:0] erd, input logic ev, em);
        vec_t v;
        v.we = we; v.rd = rd; v.a = a; v.wd = wd; v.sz = sz; v.sx = sx;
        v.erd = erd; v.ev = ev; v.em = em;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NBYTE; i++) mdl[i] = 8'h00;
        exp_rd = 32'h0;
    endtask

    task automatic ref_step(input logic we, rd, input logic [31:0] a, wd,
                            input logic [1:0] sz, input logic sx);
        int k, n;
        logic [31:0] v;
        bit bad;
        k = int'(a[7:0]);
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        bad = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
        exp_m = (we || rd) && bad;
        exp_v = rd && !bad;
        if (exp_v) begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = v | (32'(mdl[k+i]) << (8*i));
            if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
            exp_rd = v;
        end
        if (we && !bad) begin
            for (int i = 0; i < n; i++) mdl[k+i] = wd[8*i +: 8];
        end
    endtask

    task automatic apply(input logic we, rd, input logic [31:0] a, wd,
                         input logic [1:0] sz, input logic sx);
        WE = we; memread = rd; A = a; WD = wd; size = sz; sign_ext = sx;
        ref_step(we, rd, a, wd, sz, sx);
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        WE = 1'b0; memread = 1'b0; A = 32'h0; WD = 32'h0; size = 2'b10; sign_ext = 1'b0;
    endtask

    // Counts cycles of busy after release; optionally hammers requests meanwhile.
    task automatic count_busy(input string name, input bit hammer);
        int n;
        bit noisy;
        n = 0;
        noisy = 1'b0;
        if (hammer) begin
            WE = 1'b1; memread = 1'b1; A = 32'h10; WD = 32'hFFFFFFFF; size = 2'b10;
        end
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (busy && (rd_valid || misalign)) noisy = 1'b1;
        end
        idle_inputs();
        check(name, 32'(n), 32'd64);
        if (hammer) check("busy_quiet", {31'h0, noisy}, 32'h0);
        model_clear();
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd", RD, 32'h0);
        check("rst_valid", {31'h0, rd_valid}, 32'h0);
        check("rst_mis", {31'h0, misalign}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h1);
        rst_n = 1'b1;
        count_busy("busy_len", 1'b1);

        //             we    rd    a       wd            sz    sx    erd           ev    em
        tbl.push_back(mk(1'b0, 1'b1, 32'h00, 32'h0,        2'd2, 1'b0, 32'h00000000, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h7C, 32'h0,        2'd2, 1'b0, 32'h00000000, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'hFC, 32'h0,        2'd2, 1'b0, 32'h00000000, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h10, 32'h0,        2'd2, 1'b0, 32'h00000000, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 32'h20, 32'h12345678, 2'd2, 1'b0, 32'h0,        1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h20, 32'h0,        2'd0, 1'b1, 32'h00000078, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h21, 32'h0,        2'd0, 1'b1, 32'h00000056, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h22, 32'h0,        2'd0, 1'b1, 32'h00000034, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h23, 32'h0,        2'd0, 1'b1, 32'h00000012, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h22, 32'h0,        2'd1, 1'b1, 32'h00001234, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 32'h40, 32'h80FF7F80, 2'd2, 1'b0, 32'h0,        1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h40, 32'h0,        2'd0, 1'b1, 32'hFFFFFF80, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h40, 32'h0,        2'd0, 1'b0, 32'h00000080, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h42, 32'h0,        2'd1, 1'b1, 32'hFFFF80FF, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h42, 32'h0,        2'd1, 1'b0, 32'h000080FF, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 32'h30, 32'hAAAAAAAA, 2'd2, 1'b0, 32'h0,        1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 32'h31, 32'h00000011, 2'd0, 1'b0, 32'h0,        1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 32'h32, 32'h00002233, 2'd1, 1'b0, 32'h0,        1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h30, 32'h0,        2'd2, 1'b0, 32'h223311AA, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h05, 32'h0,        2'd2, 1'b0, 32'h0,        1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 32'h33, 32'h0000FFFF, 2'd1, 1'b0, 32'h0,        1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 32'h00, 32'h0,        2'd3, 1'b0, 32'h0,        1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 32'h04, 32'hFFFFFFFF, 2'd3, 1'b0, 32'h0,        1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 32'h01, 32'h0,        2'd3, 1'b0, 32'h0,        1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h04, 32'h0,        2'd2, 1'b0, 32'h00000000, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h30, 32'h0,        2'd2, 1'b0, 32'h223311AA, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 32'h50, 32'h00001111, 2'd2, 1'b0, 32'h0,        1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 32'h50, 32'h00005555, 2'd2, 1'b0, 32'h00001111, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h50, 32'h0,        2'd2, 1'b0, 32'h00005555, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 32'h104, 32'h0000CAFE, 2'd2, 1'b0, 32'h0,       1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h04, 32'h0,        2'd2, 1'b0, 32'h0000CAFE, 1'b1, 1'b0));

        foreach (tbl[i]) begin
            apply(tbl[i].we, tbl[i].rd, tbl[i].a, tbl[i].wd, tbl[i].sz, tbl[i].sx);
            check($sformatf("tbl%0d_valid", i), {31'h0, rd_valid}, {31'h0, tbl[i].ev});
            check($sformatf("tbl%0d_mis", i), {31'h0, misalign}, {31'h0, tbl[i].em});
            if (tbl[i].ev) check($sformatf("tbl%0d_rd", i), RD, tbl[i].erd);
            check($sformatf("tbl%0d_model", i), RD, exp_rd);
        end

        // Randomized traffic against the byte-array model, including wrap and
        // ignored upper address bits.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            logic        we, rd;
            we = ($urandom_range(0, 2) == 0);
            rd = ($urandom_range(0, 1) == 1);
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 2*NBYTE - 1));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            if ($urandom_range(0, 7) == 0) a[31:9] = 23'($urandom);
            apply(we, rd, a, $urandom, sz, 1'($urandom_range(0, 1)));
            check("rnd_valid", {31'h0, rd_valid}, {31'h0, exp_v});
            check("rnd_mis", {31'h0, misalign}, {31'h0, exp_m});
            check("rnd_rd", RD, exp_rd);
        end

        // Reset during the clear sequence
        apply(1'b1, 1'b0, 32'h00, 32'hDEADBEEF, 2'd2, 1'b0);
        apply(1'b0, 1'b1, 32'h00, 32'h0, 2'd2, 1'b0);
        check("pre_rst_rd", RD, 32'hDEADBEEF);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check("rst2_rd", RD, 32'h0);
        check("rst2_valid", {31'h0, rd_valid}, 32'h0);
        check("rst2_busy", {31'h0, busy}, 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("midclr_busy", {31'h0, busy}, 32'h1);
        check("midclr_mis", {31'h0, misalign}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        count_busy("busy_len2", 1'b0);
        apply(1'b0, 1'b1, 32'h00, 32'h0, 2'd2, 1'b0);
        check("post_clr_valid", {31'h0, rd_valid}, 32'h1);
        check("post_clr_rd", RD, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
